// File: rtl/instr_encoder_writer_pkg.sv
// ============================================================================
// Module : instr_encoder_writer_pkg
// Brief  : Shared kind codes, RV32I opcodes and FSM encoding for the writer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_writer_pkg;

  localparam logic [2:0] KIND_LW   = 3'd0;
  localparam logic [2:0] KIND_SW   = 3'd1;
  localparam logic [2:0] KIND_R    = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_IALU = 3'd4;
  localparam logic [2:0] KIND_JAL  = 3'd5;

  // Opcodes must stay in lockstep with main_decoder.
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_encoder_writer_encode_word.sv
// ============================================================================
// Module : instr_encode_word
// Brief  : Combinational RV32I field packer with immediate range checking.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encode_word
  import instr_encoder_writer_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  logic fits_12;
  logic fits_13_even;
  logic even;

  // A value fits N signed bits when every bit above N-1 equals the sign bit.
  assign fits_12      = (imm[20:11] == {10{imm[11]}});
  assign fits_13_even = (imm[20:12] == {9{imm[12]}}) && !imm[0];
  assign even         = !imm[0];

  always_comb begin
    word      = 32'd0;
    range_err = 1'b0;
    case (kind)
      KIND_LW: begin
        word      = {imm[11:0], rs1, F3_W, rd, OP_LW};
        range_err = !fits_12;
      end
      KIND_SW: begin
        word      = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_SW};
        range_err = !fits_12;
      end
      KIND_R: begin
        word      = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      end
      KIND_BEQ: begin
        word      = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
        range_err = !fits_13_even;
      end
      KIND_IALU: begin
        word      = {imm[11:0], rs1, funct3, rd, OP_IALU};
        range_err = !fits_12;
      end
      KIND_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        range_err = !even;
      end
      default: begin
        word      = 32'd0;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_writer.sv
// ============================================================================
// Module : instr_encoder_writer
// Brief  : Streams decoded instruction bundles into imem as encoded RV32I words.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_writer
  import instr_encoder_writer_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        kind,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [20:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              full
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [31:0]     enc_word;
  logic            enc_err;
  logic [ADDR_W:0] slot;
  logic [ADDR_W:0] slot_next;
  logic            accept;
  logic            write_ok;
  logic            fills;

  instr_encode_word u_encode (
    .kind      (kind),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .word      (enc_word),
    .range_err (enc_err)
  );

  // count lags the output register by one cycle, so the pending write
  // already owns the next slot when a back-to-back bundle arrives.
  assign slot      = count + {{ADDR_W{1'b0}}, imem_we};
  assign slot_next = slot + ONE_C;

  assign full     = (count == DEPTH_C);
  assign busy     = (state != ST_IDLE);
  assign in_ready = (state == ST_RUN) && (slot != DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign write_ok = accept && !enc_err;
  assign fills    = write_ok && (slot_next == DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_C;
      imem_wdata <= 32'd0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (imem_we) begin
        count <= count + ONE_C;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= '0;
            err   <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (write_ok) begin
              imem_we    <= 1'b1;
              imem_addr  <= BASE_C + slot[ADDR_W-1:0];
              imem_wdata <= enc_word;
            end
            if (enc_err) begin
              err <= 1'b1;
            end
            if (in_last) begin
              state <= ST_FLUSH;
            end else if (fills) begin
              // Memory filled before the stream said it was finished.
              err   <= 1'b1;
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_writer.sv
// ============================================================================
// Module : tb_instr_encoder_writer
// Brief  : Directed table-driven bench for instr_encoder_writer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_writer;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  vec_t tv [11];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  kind;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [20:0] imm;

  logic        in_ready, imem_we, busy, done, err, full;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_imem_we, s_busy, s_done, s_err, s_full;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_addr = 0;

  always #5 clk = ~clk;

  instr_encoder_writer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .kind(kind), .funct3(funct3),
    .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .err(err), .full(full)
  );

  // Tiny instance: memory fills after four words and addresses wrap from 3 to 0.
  instr_encoder_writer #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_last(in_last), .kind(kind), .funct3(funct3),
    .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .count(s_count), .busy(s_busy), .done(s_done), .err(s_err), .full(s_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic last);
    start    = 1'b0;
    kind     = tv[i].kind;
    funct3   = tv[i].f3;
    funct7b5 = tv[i].f7;
    rd       = tv[i].rd;
    rs1      = tv[i].rs1;
    rs2      = tv[i].rs2;
    imm      = tv[i].imm;
    in_valid = 1'b1;
    in_last  = last;
  endtask

  task automatic start_session();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b1;
    exp_addr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic last);
    @(negedge clk);
    drive(i, last);
    chk($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk($sformatf("imem_we[%0d]", i), 32'(imem_we), 32'(!tv[i].bad));
    if (!tv[i].bad) begin
      chk($sformatf("imem_addr[%0d]", i), 32'(imem_addr), 32'(exp_addr));
      chk($sformatf("imem_wdata[%0d]", i), imem_wdata, tv[i].word);
      exp_addr++;
    end
  endtask

  task automatic finish(input int exp_count, input logic exp_err);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("count_end", 32'(count), 32'(exp_count));
    chk("err_end", 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    //         kind  f3     f7    rd     rs1    rs2    imm           word          bad
    tv[0]  = '{3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5,        32'h00500093, 1'b0}; // addi x1,x0,5
    tv[1]  = '{3'd0, 3'd7, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8,        32'h0080A103, 1'b0}; // lw x2,8(x1)
    tv[2]  = '{3'd1, 3'd5, 1'b0, 5'd0, 5'd1, 5'd2, 21'd12,       32'h0020A623, 1'b0}; // sw x2,12(x1)
    tv[3]  = '{3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0,        32'h002081B3, 1'b0}; // add x3,x1,x2
    tv[4]  = '{3'd3, 3'd7, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC,   32'hFE208EE3, 1'b0}; // beq x1,x2,-4
    tv[5]  = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8,        32'h008000EF, 1'b0}; // jal x1,8
    tv[6]  = '{3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd2048,     32'h00000000, 1'b1}; // addi imm 2048
    tv[7]  = '{3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3,        32'h00000000, 1'b1}; // beq odd
    tv[8]  = '{3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 21'd0,        32'h00000000, 1'b1}; // illegal kind
    tv[9]  = '{3'd2, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 21'd0,        32'h407302B3, 1'b0}; // sub x5,x6,x7
    tv[10] = '{3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h1FF800,   32'h80000093, 1'b0}; // addi x1,x0,-2048

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    kind = 3'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 21'd0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_small_addr", 32'(s_imem_addr), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;

    // Valid input while idle must be ignored.
    @(negedge clk);
    drive(0, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_no_write", 32'(imem_we), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    start_session();
    send(0, 1'b1);
    finish(1, 1'b0);

    start_session();
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b1);
    finish(3, 1'b0);

    start_session();
    send(4, 1'b0);
    send(5, 1'b1);
    finish(2, 1'b0);

    start_session();
    send(6, 1'b0);
    send(7, 1'b0);
    send(8, 1'b0);
    chk("err_sticky_mid", 32'(err), 32'd1);
    chk("count_after_bad", 32'(count), 32'd0);
    send(10, 1'b0);
    send(9, 1'b1);
    finish(2, 1'b1);

    // Fill the four-word instance without in_last.
    start_session();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(0, 1'b0);
      chk($sformatf("small_ready[%0d]", i), 32'(s_in_ready), 32'(i < 4));
      @(posedge clk);
      #1;
      chk($sformatf("small_we[%0d]", i), 32'(s_imem_we), 32'(i < 4));
      if (i < 4) begin
        chk($sformatf("small_addr[%0d]", i), 32'(s_imem_addr), 32'((2 + i) % 4));
        chk($sformatf("small_wdata[%0d]", i), s_imem_wdata, 32'h00500093);
      end
      if (i == 4) begin
        chk("small_done", 32'(s_done), 32'd1);
        chk("small_full", 32'(s_full), 32'd1);
        chk("small_err", 32'(s_err), 32'd1);
        chk("small_count", 32'(s_count), 32'd4);
      end
      if (i == 5) begin
        chk("small_done_clear", 32'(s_done), 32'd0);
        chk("small_idle", 32'(s_busy), 32'd0);
        chk("small_full_hold", 32'(s_full), 32'd1);
      end
    end

    // Main instance stayed in its session: start is ignored and count continues at 6.
    start_session();
    exp_addr = 6;
    send(0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(imem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    start_session();
    send(3, 1'b1);
    finish(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
